// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] BUBBLE_INSTR = 32'hffffffff;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pcadd;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_fetch_queue.sv
// Synchronous FIFO holding fetched {instr, PC+4} entries; clear flushes it in one cycle.
module fetch_queue
  import if_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues req/ack word fetches and feeds IF/ID from a prefetch queue.
// Optional same-cycle bypass of an empty queue is enabled by defining IF_PREFETCH_BYPASS_EN.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pcadd
);

  localparam int               CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);

  fetch_state_t     state;
  logic [31:0]      fetch_pc;
  logic             q_push;
  logic             q_pop;
  logic             q_clear;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     q_wdata;
  logic             take_ack;
  logic             bypass_hit;
  logic             fills_up;

  assign take_ack = (state == S_REQ) && imem_ack;

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass_hit = q_empty && take_ack && !stall && !redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  // Redirect wins over push and pop: the queue is flushed and any returning word dropped.
  assign q_clear  = redirect;
  assign q_push   = take_ack && !redirect && !bypass_hit;
  assign q_pop    = !stall && !q_empty && !redirect;
  assign q_wdata  = '{instr: imem_rdata, pcadd: next_pc(fetch_pc)};
  assign fills_up = (q_count == LAST_C) && q_push && !q_pop;

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (q_clear),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // imem_addr always equals fetch_pc while in S_REQ; S_DISCARD keeps the stale address until its ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc  <= redirect_pc;
            imem_addr <= redirect_pc;
            imem_req  <= 1'b1;
            state     <= S_REQ;
          end else if (!q_full) begin
            imem_addr <= fetch_pc;
            imem_req  <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            if (redirect) begin
              fetch_pc  <= redirect_pc;
              imem_addr <= redirect_pc;
            end else begin
              fetch_pc  <= next_pc(fetch_pc);
              imem_addr <= next_pc(fetch_pc);
              if (fills_up) begin
                imem_req <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end else if (redirect) begin
            fetch_pc <= redirect_pc;
            state    <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    if_valid = !q_empty;
    if_instr = q_empty ? BUBBLE_INSTR : q_head.instr;
    if_pcadd = q_empty ? 32'h0 : q_head.pcadd;
`ifdef IF_PREFETCH_BYPASS_EN
    if (bypass_hit) begin
      if_valid = 1'b1;
      if_instr = imem_rdata;
      if_pcadd = next_pc(imem_addr);
    end
`endif
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: directed scenarios plus randomized stall/redirect/latency traffic,
// scored against the in-order stream of words the program should deliver.
module tb_if_prefetch_unit;
  import if_prefetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pcadd;

  always #5 clk = ~clk;

  if_prefetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pcadd    (if_pcadd)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_pc;
  int          wait_cnt;
  int          lat;
  bit          rand_lat;
  logic [31:0] ack_log [$];
  int          req_started;
  bit          prev_out;
  logic [31:0] prev_addr;
  bit          last_ack;
  int          pops;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h20080005;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic modelReset();
    exp_pc      = RESET_PC;
    wait_cnt    = 0;
    ack_log.delete();
    req_started = 0;
    prev_out    = 1'b0;
    last_ack    = 1'b0;
    pops        = 0;
  endtask

  task automatic doReset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req",   32'(imem_req), 32'd0);
    checkOutput("rst_addr",  imem_addr, RESET_PC);
    checkOutput("rst_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_instr", if_instr, BUBBLE_INSTR);
    checkOutput("rst_pcadd", if_pcadd, 32'd0);
    rst = 1'b0;
    modelReset();
  endtask

  // One clock cycle: memory responds, inputs are driven, then the delivered stream is scored.
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc, input bit rd_on_ack);
    @(posedge clk); #1;
    if (imem_req && wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
    stall       = st;
    redirect    = rd || (rd_on_ack && imem_ack);
    redirect_pc = rpc;
    #3;
    if (prev_out) begin
      checkOutput("req_held",  32'(imem_req), 32'd1);
      checkOutput("addr_held", imem_addr, prev_addr);
    end else if (imem_req) begin
      req_started++;
    end
    if (imem_ack) ack_log.push_back(imem_addr);
    last_ack = imem_ack;
    if (if_valid) begin
      checkOutput("instr", if_instr, mem_word(exp_pc));
      checkOutput("pcadd", if_pcadd, exp_pc + 32'd4);
    end else begin
      checkOutput("bubble_instr", if_instr, BUBBLE_INSTR);
      checkOutput("bubble_pcadd", if_pcadd, 32'd0);
    end
    if (redirect) exp_pc = redirect_pc;
    else if (if_valid && !stall) begin
      exp_pc += 32'd4;
      pops++;
    end
    prev_out  = imem_req && !imem_ack;
    prev_addr = imem_addr;
    if (imem_ack) begin
      wait_cnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (imem_req) begin
      wait_cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit hit;
    rand_lat = 1'b0;
    lat      = 0;

    // Zero-wait memory, no stall.
    doReset();
    hit = 1'b0;
    for (int i = 0; i < 5 && !hit; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      hit = last_ack;
    end
    checkOutput("first_ack_seen", 32'(hit), 32'd1);
`ifdef IF_PREFETCH_BYPASS_EN
    checkOutput("bypass_valid", 32'(if_valid), 32'd1);
    checkOutput("bypass_instr", if_instr, 32'h20080005);
    checkOutput("bypass_pcadd", if_pcadd, 32'd4);
`else
    checkOutput("first_valid_late", 32'(if_valid), 32'd0);
`endif
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("zw_ack_count", ack_log.size(), 32'd9);
    if (ack_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("zw_addr", ack_log[i], 32'(i * 4));
    end

    // 3-cycle latency with a long stall fills the queue, then drains in order.
    doReset();
    lat = 3;
    repeat (20) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_requests", req_started, 32'd4);
    checkOutput("stall_req_low",  32'(imem_req), 32'd0);
    checkOutput("stall_acks",     ack_log.size(), 32'd4);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain_pops", 32'(pops >= 4), 32'd1);
    if (ack_log.size() >= 5) checkOutput("resume_addr", ack_log[4], 32'd16);
    else checkOutput("resume_ack_seen", ack_log.size(), 32'd5);

    // Redirect while the fetch of 8 is still waiting for its ack.
    doReset();
    lat = 3;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      hit = imem_req && (imem_addr == 32'd8) && (wait_cnt == 1);
    end
    checkOutput("req8_seen", 32'(hit), 32'd1);
    n = ack_log.size();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 20 && ack_log.size() < n + 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    if (ack_log.size() >= n + 2) begin
      checkOutput("stale_addr",    ack_log[n],     32'd8);
      checkOutput("redirect_addr", ack_log[n + 1], 32'h100);
    end else checkOutput("redirect_acks", ack_log.size(), 32'(n + 2));
    hit = if_valid;
    for (int i = 0; i < 10 && !hit; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      hit = if_valid;
    end
    checkOutput("redirect_pcadd", if_pcadd, 32'h104);

    // Redirect coinciding with an ack while the queue is nearly full under stall.
    doReset();
    lat = 3;
    for (int i = 0; i < 40 && ack_log.size() < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("prefill_acks", ack_log.size(), 32'd3);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h200, 1'b1);
      hit = last_ack;
    end
    checkOutput("ack_redirect_seen", 32'(hit), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("flush_valid", 32'(if_valid), 32'd0);
    n = ack_log.size();
    for (int i = 0; i < 10 && ack_log.size() == n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    if (ack_log.size() > n) checkOutput("flush_next_addr", ack_log[n], 32'h200);
    else checkOutput("flush_next_ack", ack_log.size(), 32'(n + 1));

    // Asynchronous reset while a discarded request is still outstanding.
    doReset();
    lat = 5;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("discard_req", 32'(imem_req), 32'd1);
    #1 rst = 1'b1;
    imem_ack = 1'b0; redirect = 1'b0;
    #1;
    checkOutput("async_req",   32'(imem_req), 32'd0);
    checkOutput("async_addr",  imem_addr, RESET_PC);
    checkOutput("async_valid", 32'(if_valid), 32'd0);
    checkOutput("async_instr", if_instr, BUBBLE_INSTR);
    checkOutput("async_pcadd", if_pcadd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    lat = 1;
    for (int i = 0; i < 10 && ack_log.size() == 0; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    if (ack_log.size() > 0) checkOutput("post_rst_addr", ack_log[0], RESET_PC);
    else checkOutput("post_rst_ack", 32'd0, 32'd1);

    // Randomized traffic scored against the expected instruction stream.
    doReset();
    rand_lat = 1'b1;
    lat      = $urandom_range(0, 3);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 4,
                    32'($urandom_range(0, 1023)) << 2,
                    $urandom_range(0, 99) < 3);
    end
    checkOutput("random_progress", 32'(pops > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
